fpu_add_sequencer: RTL and testbench

Multi-cycle sequencer for the single-precision FP add/subtract datapath. Accepts a start pulse, then steps the datapath through alignment, mantissa add, normalization and rounding by driving its mux, shift and exponent-adjust controls cycle by cycle. Status flags from the datapath steer the transitions. Sits between the execute-stage issue logic and the FPU adder datapath; one operation in flight at a time.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_shift_sat.sv | 27 ++
 rtl/fpu_add_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fpu_add_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Types and sizing shared by the FP adder sequencer and the adder datapath.
package fpu_pkg;

    localparam int EXP_W     = 8;
    localparam int ALIGN_MAX = 26;
    localparam int NORM_MAX  = 24;
    localparam int LZ_W      = 5;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_RCHK  = 3'd5,
        ST_DONE  = 3'd6
    } fpu_add_state_e;

endpackage

// File: rtl/fpu_shift_sat.sv
// Magnitude of the signed exponent difference, saturated to the widest useful
// alignment shift. The most negative difference has no positive twin, so the
// magnitude is formed one bit wider before saturating.
module fpu_shift_sat
    import fpu_pkg::*;
(
    input  logic [EXP_W-1:0] diff_i,
    output logic [EXP_W-1:0] shift_o
);

    logic [EXP_W:0] mag;

    always_comb begin
        if (diff_i[EXP_W-1]) begin
            mag = {1'b0, ~diff_i} + (EXP_W+1)'(1);
        end else begin
            mag = {1'b0, diff_i};
        end

        if (mag > (EXP_W+1)'(ALIGN_MAX)) begin
            shift_o = EXP_W'(ALIGN_MAX);
        end else begin
            shift_o = mag[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/fpu_add_sequencer.sv
// Multi-cycle control sequencer for the single-precision FP add/subtract datapath.
// Define FPU_ADD_SEQ_FASTNORM_EN for single-step leading-zero normalization.
//
//   state | meaning
//   IDLE  | waiting for start; all controls low
//   ALIGN | select larger operand, right-shift smaller mantissa, load fractions
//   ADD   | mantissa add/subtract
//   NORM  | normalize: right shift on carry, left shift until hidden bit set
//   ROUND | apply rounding
//   RCHK  | fix up a rounding carry (may overflow to infinity)
//   DONE  | one-cycle completion, load result
module fpu_add_sequencer
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EXP_W-1:0] expDiff,
    input  logic             sumZero,
    input  logic             sumOvf,
    input  logic             hiddenBit,
    input  logic             expMin,
    input  logic             expMax,
    input  logic             roundCarry,
    input  logic [LZ_W-1:0]  lzCount,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             swapSel,
    output logic [EXP_W-1:0] alignShift,
    output logic             fracLoad,
    output logic             aluEn,
    output logic             roundEn,
    output logic             resultLoad,
    output logic             shiftR,
    output logic             shiftL,
    output logic             expInc,
    output logic             expDec,
    output logic [LZ_W-1:0]  normShift
);

    fpu_add_state_e   state_q, state_d;
    logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
    logic             ovf_q, ovf_d;
    logic [EXP_W-1:0] align_sat;

`ifdef FPU_ADD_SEQ_FASTNORM_EN
    logic unused_iter;
    assign unused_iter = hiddenBit ^ expMin;
`else
    logic [CNT_W-1:0] norm_cnt_q, norm_cnt_d;
    logic             unused_lz;
    assign unused_lz = ^lzCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_cnt_q <= '0;
        end else begin
            norm_cnt_q <= norm_cnt_d;
        end
    end
`endif

    fpu_shift_sat u_shift_sat (
        .diff_i  (exp_diff_q),
        .shift_o (align_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            exp_diff_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_diff_q <= exp_diff_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_diff_d = exp_diff_q;
        ovf_d      = ovf_q;
`ifndef FPU_ADD_SEQ_FASTNORM_EN
        norm_cnt_d = norm_cnt_q;
`endif
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        swapSel    = 1'b0;
        alignShift = '0;
        fracLoad   = 1'b0;
        aluEn      = 1'b0;
        roundEn    = 1'b0;
        resultLoad = 1'b0;
        shiftR     = 1'b0;
        shiftL     = 1'b0;
        expInc     = 1'b0;
        expDec     = 1'b0;
        normShift  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_diff_d = expDiff;
                    ovf_d      = 1'b0;
                    state_d    = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                swapSel    = exp_diff_q[EXP_W-1];
                alignShift = align_sat;
                fracLoad   = 1'b1;
                state_d    = ST_ADD;
            end

            ST_ADD: begin
                aluEn = 1'b1;
`ifndef FPU_ADD_SEQ_FASTNORM_EN
                norm_cnt_d = '0;
`endif
                state_d = ST_NORM;
            end

            // A zero sum bypasses rounding; a carry needs one right shift.
            ST_NORM: begin
                if (sumZero) begin
                    state_d = ST_DONE;
                end else if (sumOvf) begin
                    shiftR = 1'b1;
                    expInc = 1'b1;
                    if (expMax) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ROUND;
                    end
                end else begin
`ifdef FPU_ADD_SEQ_FASTNORM_EN
                    if (lzCount != '0) begin
                        shiftL    = 1'b1;
                        expDec    = 1'b1;
                        normShift = lzCount;
                    end
                    state_d = ST_ROUND;
`else
                    if (!hiddenBit && !expMin && (norm_cnt_q < CNT_W'(NORM_MAX))) begin
                        shiftL     = 1'b1;
                        expDec     = 1'b1;
                        norm_cnt_d = norm_cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_ROUND;
                    end
`endif
                end
            end

            ST_ROUND: begin
                roundEn = 1'b1;
                state_d = ST_RCHK;
            end

            ST_RCHK: begin
                if (roundCarry) begin
                    shiftR = 1'b1;
                    expInc = 1'b1;
                    if (expMax) begin
                        ovf_d = 1'b1;
                    end
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                done       = 1'b1;
                resultLoad = 1'b1;
                ovf_d      = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Scoreboard bench for fpu_add_sequencer: a driver plays directed operations
// and queues expected responses; a monitor checks each completed operation.
module tb_fpu_add_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] expDiff;
    logic       sumZero, sumOvf, hiddenBit, expMin, expMax, roundCarry;
    logic [4:0] lzCount;
    logic       busy, done, ovf, swapSel;
    logic [7:0] alignShift;
    logic       fracLoad, aluEn, roundEn, resultLoad;
    logic       shiftR, shiftL, expInc, expDec;
    logic [4:0] normShift;

    fpu_add_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .expDiff    (expDiff),
        .sumZero    (sumZero),
        .sumOvf     (sumOvf),
        .hiddenBit  (hiddenBit),
        .expMin     (expMin),
        .expMax     (expMax),
        .roundCarry (roundCarry),
        .lzCount    (lzCount),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .swapSel    (swapSel),
        .alignShift (alignShift),
        .fracLoad   (fracLoad),
        .aluEn      (aluEn),
        .roundEn    (roundEn),
        .resultLoad (resultLoad),
        .shiftR     (shiftR),
        .shiftL     (shiftL),
        .expInc     (expInc),
        .expDec     (expDec),
        .normShift  (normShift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ed;
        bit         sz, so, emax, emin, rc;
        int         nlow;
        logic [4:0] lz;
        bit         pbusy, pdone;
        bit         sw;
        logic [7:0] al;
        bit         ov;
        int         lat_it, lat_fn, shl_it, shl_fn, nsr;
    } vec_t;

    typedef struct {
        int         lat;
        bit         ov;
        bit         sw;
        logic [7:0] al;
        int         nshl, nsr, nsum, nround;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] ed, input bit sz, so, emax, emin, rc,
                                input int nlow, input logic [4:0] lz, input bit pb, pd,
                                input bit sw, input logic [7:0] al, input bit ov,
                                input int lat_it, lat_fn, shl_it, shl_fn, nsr);
        vec_t v;
        v.ed = ed; v.sz = sz; v.so = so; v.emax = emax; v.emin = emin; v.rc = rc;
        v.nlow = nlow; v.lz = lz; v.pbusy = pb; v.pdone = pd;
        v.sw = sw; v.al = al; v.ov = ov;
        v.lat_it = lat_it; v.lat_fn = lat_fn; v.shl_it = shl_it; v.shl_fn = shl_fn; v.nsr = nsr;
        return v;
    endfunction

    // Monitor: tracks one operation from accepted start to done.
    bit         mon_active = 1'b0;
    int         mon_cyc, m_nfl, m_alu, m_rnd, m_shl, m_dec, m_shr, m_inc, m_sum;
    bit         m_sw;
    logic [7:0] m_al;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                mon_cyc++;
                if (fracLoad) begin
                    m_sw = swapSel;
                    m_al = alignShift;
                end
                m_nfl += int'(fracLoad);
                m_alu += int'(aluEn);
                m_rnd += int'(roundEn);
                m_shl += int'(shiftL);
                m_dec += int'(expDec);
                m_shr += int'(shiftR);
                m_inc += int'(expInc);
                m_sum += int'(normShift);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = sb_q.pop_front();
                        chk("latency", mon_cyc, e.lat);
                        chk("ovf", ovf, e.ov);
                        chk("swapSel", m_sw, e.sw);
                        chk("alignShift", m_al, e.al);
                        chk("fracLoad_cnt", m_nfl, 1);
                        chk("aluEn_cnt", m_alu, 1);
                        chk("roundEn_cnt", m_rnd, e.nround);
                        chk("shiftL_cnt", m_shl, e.nshl);
                        chk("expDec_cnt", m_dec, e.nshl);
                        chk("shiftR_cnt", m_shr, e.nsr);
                        chk("expInc_cnt", m_inc, e.nsr);
                        chk("normShift_sum", m_sum, e.nsum);
                        chk("resultLoad", resultLoad, 1);
                    end
                    mon_active = 1'b0;
                end else if (mon_cyc > 120) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_timeout actual=%0d required<=120", mon_cyc);
                    mon_active = 1'b0;
                end
            end else begin
                chk("idle_done", done, 0);
                chk("idle_ovf", ovf, 0);
            end
            if (start && !busy) begin
                mon_active = 1'b1;
                mon_cyc = 0;
                m_nfl = 0; m_alu = 0; m_rnd = 0; m_shl = 0; m_dec = 0;
                m_shr = 0; m_inc = 0; m_sum = 0;
                m_sw = 1'b0; m_al = '0;
            end
        end
    end

    // Driver: called at posedge+#1 with the DUT idle; returns the same way.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   k;
        bit   seen_idle;
`ifdef FPU_ADD_SEQ_FASTNORM_EN
        e.lat  = v.lat_fn;
        e.nshl = v.shl_fn;
        e.nsum = (v.shl_fn != 0) ? int'(v.lz) : 0;
`else
        e.lat  = v.lat_it;
        e.nshl = v.shl_it;
        e.nsum = 0;
`endif
        e.ov     = v.ov;
        e.sw     = v.sw;
        e.al     = v.al;
        e.nsr    = v.nsr;
        e.nround = (v.sz || (v.so && v.emax)) ? 0 : 1;
        sb_q.push_back(e);

        start = 1'b1; expDiff = v.ed;
        sumZero = v.sz; sumOvf = v.so; expMax = v.emax; expMin = v.emin;
        roundCarry = v.rc; lzCount = v.lz; hiddenBit = 1'b1;
        k = 0;
        seen_idle = 1'b0;
        while (!seen_idle && k < 80) begin
            @(posedge clk); #1;
            k++;
            start     = 1'b0;
            expDiff   = 8'(k * 37 + 11);
            hiddenBit = !(k >= 3 && k < 3 + v.nlow);
            if (v.pbusy && k == 2) begin
                start = 1'b1; expDiff = 8'h9C;
            end
            if (v.pdone && k == e.lat) begin
                start = 1'b1; expDiff = 8'h11;
            end
            if (v.pdone && k == e.lat + 1) chk("start_in_done_ignored", busy, 0);
            if (k >= 2 && !busy) seen_idle = 1'b1;
        end
        if (!seen_idle) begin
            checks++;
            failures++;
            $display("FAIL drv_timeout actual=%0d required<80", k);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; expDiff = '0;
        sumZero = 1'b0; sumOvf = 1'b0; hiddenBit = 1'b1; expMin = 1'b0;
        expMax = 1'b0; roundCarry = 1'b0; lzCount = '0;

        //                ed     sz so mx mn rc nlow lz  pb pd sw al     ov lat_it lat_fn shl_it shl_fn nsr
        vecs.push_back(mk(8'd3,   0, 0, 0, 0, 0, 0,  5'd0, 0, 0, 0, 8'd3,  0, 6,  6, 0,  0, 0));
        vecs.push_back(mk(8'hD8,  0, 0, 0, 0, 0, 0,  5'd0, 0, 0, 1, 8'd26, 0, 6,  6, 0,  0, 0));
        vecs.push_back(mk(8'd5,   0, 0, 0, 0, 0, 3,  5'd3, 0, 0, 0, 8'd5,  0, 9,  6, 3,  1, 0));
        vecs.push_back(mk(8'd0,   0, 1, 1, 0, 0, 0,  5'd0, 0, 0, 0, 8'd0,  1, 4,  4, 0,  0, 1));
        vecs.push_back(mk(8'hFE,  0, 0, 0, 0, 1, 0,  5'd0, 0, 0, 1, 8'd2,  0, 6,  6, 0,  0, 1));
        vecs.push_back(mk(8'd26,  1, 0, 0, 0, 0, 5,  5'd7, 0, 0, 0, 8'd26, 0, 4,  4, 0,  0, 0));
        vecs.push_back(mk(8'h80,  0, 0, 0, 0, 0, 0,  5'd0, 1, 0, 1, 8'd26, 0, 6,  6, 0,  0, 0));
        vecs.push_back(mk(8'd127, 0, 1, 0, 0, 0, 0,  5'd0, 0, 0, 0, 8'd26, 0, 6,  6, 0,  0, 1));
        vecs.push_back(mk(8'd1,   0, 0, 1, 0, 1, 0,  5'd0, 0, 1, 0, 8'd1,  1, 6,  6, 0,  0, 1));
        vecs.push_back(mk(8'hFF,  0, 0, 0, 1, 0, 2,  5'd0, 0, 0, 1, 8'd1,  0, 6,  6, 0,  0, 0));
        vecs.push_back(mk(8'd27,  0, 0, 0, 0, 0, 30, 5'd0, 0, 0, 0, 8'd26, 0, 30, 6, 24, 0, 0));
        vecs.push_back(mk(8'hE6,  0, 1, 0, 0, 0, 4,  5'd4, 0, 0, 1, 8'd26, 0, 6,  6, 0,  0, 1));
        vecs.push_back(mk(8'd25,  0, 0, 1, 0, 0, 1,  5'd1, 0, 0, 0, 8'd25, 0, 7,  6, 1,  1, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_fracLoad", fracLoad, 0);
        chk("rst_alignShift", alignShift, 0);
        chk("rst_shift", {shiftL, shiftR, expInc, expDec}, 0);
        chk("rst_normShift", normShift, 0);
        chk("rst_resultLoad", resultLoad, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while iterating in NORM: operation abandoned, no completion.
        start = 1'b1; expDiff = 8'd4;
        sumZero = 1'b0; sumOvf = 1'b0; expMax = 1'b0; expMin = 1'b0;
        roundCarry = 1'b0; lzCount = 5'd0; hiddenBit = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ovf", ovf, 0);
        chk("rst_mid_shiftL", shiftL, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hiddenBit = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[2]);
        run_vec(vecs[0]);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0t required<100000", $time);
        $fatal(1, "bench timeout");
    end

endmodule
